// File: rtl/rpc_reg_init_seq_pkg.sv
// Shared types for the register-bus init sequencer: opcode encoding,
// table entry layout and FSM state encoding.
package rpc_reg_init_pkg;

  localparam int REG_ADDR_W = 48;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_WAIT  = 2'd2,
    OP_END   = 2'd3
  } op_e;

  // One table entry; op sits in the MSBs, mask in the LSBs.
  typedef struct packed {
    op_e                   op;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
    logic [REG_DATA_W-1:0] mask;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_POLL_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Index width that never collapses to zero bits for a one-entry table.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rpc_reg_init_seq_if.sv
// Register-bus request/response bundle between the init sequencer
// (master) and the RPC controller's register responder (slave).
interface rpc_reg_init_seq_if
  import rpc_reg_init_pkg::*;
#(
  parameter int AddrWidth = REG_ADDR_W,
  parameter int DataWidth = REG_DATA_W
);

  logic [AddrWidth-1:0]   reg_addr_o;
  logic                   reg_write_o;
  logic [DataWidth-1:0]   reg_wdata_o;
  logic [DataWidth/8-1:0] reg_wstrb_o;
  logic                   reg_valid_o;
  logic [DataWidth-1:0]   reg_rdata_i;
  logic                   reg_ready_i;
  logic                   reg_error_i;

  modport master (
    output reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, reg_valid_o,
    input  reg_rdata_i, reg_ready_i, reg_error_i
  );

  modport slave (
    input  reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, reg_valid_o,
    output reg_rdata_i, reg_ready_i, reg_error_i
  );

endinterface

// File: rtl/rpc_reg_init_seq.sv
// Table-driven register-bus initiator: brings up the RPC controller's
// timing/config registers after reset by walking write/poll/wait entries.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | out of reset, waiting for start_i
// FETCH      | decode table entry at idx, no bus activity
// REQ        | reg_valid_o high, request held until reg_ready_i
// POLL_GAP   | idle PollGap cycles between poll reads
// DELAY      | WAIT entry, down-counting max(data,1) cycles
// DONE       | table finished cleanly, done_o sticky
// ERROR      | bus error or poll timeout, error_o/err_idx_o sticky
module rpc_reg_init_seq
  import rpc_reg_init_pkg::*;
#(
  parameter int  NumEntries   = 16,
  parameter int  RegAddrWidth = REG_ADDR_W,
  parameter int  RegDataWidth = REG_DATA_W,
  parameter int  PollGap      = 8,
  parameter int  PollTimeout  = 1024,
  localparam int IdxW         = clog2_min1(NumEntries)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  entry_t [NumEntries-1:0] table_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [IdxW-1:0]         err_idx_o,
  rpc_reg_init_seq_if.master      bus
);

  localparam int StrbW = RegDataWidth / 8;
  localparam int GapW  = $clog2(PollGap + 1);
  localparam int PollW = $clog2(PollTimeout + 1);

  localparam logic [GapW-1:0]  GapLoad  = GapW'(PollGap - 1);
  localparam logic [PollW-1:0] PollLast = PollW'(PollTimeout - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumEntries - 1);

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [PollW-1:0]        poll_cnt_q, poll_cnt_d;
  logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [RegDataWidth-1:0] dly_cnt_q, dly_cnt_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [IdxW-1:0]         err_idx_q, err_idx_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [RegDataWidth-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]        wstrb_q, wstrb_d;
  logic                    valid_q, valid_d;

  entry_t cur;
  logic   halted;
  logic   start_go;
  logic   xfer;
  logic   rd_match;
  logic   last;
  state_e adv_st;

  assign cur      = table_i[idx_q];
  assign halted   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign start_go = halted && start_i;
  assign xfer     = valid_q && bus.reg_ready_i;
  assign rd_match = (bus.reg_rdata_i & cur.mask) == (cur.data & cur.mask);
  assign last     = (idx_q == IdxLast);
  // Running off the end of the table without an END entry finishes cleanly.
  assign adv_st   = last ? ST_DONE : ST_FETCH;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        case (cur.op)
          OP_WRITE, OP_POLL: state_d = ST_REQ;
          OP_WAIT:           state_d = ST_DELAY;
          default:           state_d = ST_DONE;
        endcase
      end
      ST_REQ: begin
        if (xfer) begin
          if (bus.reg_error_i)           state_d = ST_ERROR;
          else if (write_q || rd_match)  state_d = adv_st;
          else if (poll_cnt_q == PollLast) state_d = ST_ERROR;
          else                           state_d = ST_POLL_GAP;
        end
      end
      ST_POLL_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_REQ;
      end
      ST_DELAY: begin
        // Terminal count at 1 so WAIT n lasts n cycles and WAIT 0 lasts one.
        if (dly_cnt_q <= RegDataWidth'(1)) state_d = adv_st;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for counters, status flags and the registered bus request.
  always_comb begin
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    done_d     = done_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    valid_d    = (state_d == ST_REQ);

    if (start_go) begin
      idx_d      = '0;
      poll_cnt_d = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_idx_d  = '0;
    end
    if (state_d == ST_DONE && state_q != ST_DONE) done_d = 1'b1;
    if (state_d == ST_ERROR && state_q != ST_ERROR) begin
      error_d   = 1'b1;
      err_idx_d = idx_q;
    end

    unique case (state_q)
      ST_FETCH: begin
        addr_d    = cur.addr;
        write_d   = (cur.op == OP_WRITE);
        wdata_d   = (cur.op == OP_WRITE) ? cur.data : '0;
        wstrb_d   = (cur.op == OP_WRITE) ? '1 : '0;
        dly_cnt_d = cur.data;
      end
      ST_REQ: begin
        if (xfer) begin
          if (state_d == ST_FETCH) idx_d = idx_q + 1'b1;
          if (state_d == ST_POLL_GAP) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            gap_cnt_d  = GapLoad;
          end else begin
            poll_cnt_d = '0;
          end
        end
      end
      ST_POLL_GAP: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
      end
      ST_DELAY: begin
        if (state_d == ST_FETCH)      idx_d     = idx_q + 1'b1;
        else if (state_d == ST_DELAY) dly_cnt_d = dly_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; valid drops asynchronously with reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      dly_cnt_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      valid_q    <= valid_d;
    end
  end

  assign busy_o    = !halted;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign err_idx_o = err_idx_q;

  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_write_o = write_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_wstrb_o = wstrb_q;
  assign bus.reg_valid_o = valid_q;

endmodule

// File: tb/tb_rpc_reg_init_seq.sv
// Bench for rpc_reg_init_seq: directed vector table, mid-request reset,
// then random tables checked against a transaction-level model.
module tb_rpc_reg_init_seq;
  import rpc_reg_init_pkg::*;

  localparam int NE = 8;
  localparam int PG = 8;
  localparam int PT = 4;

  typedef entry_t [NE-1:0] tbl_t;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [47:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xfer_t;

  typedef struct {
    string       nm;
    tbl_t        t;
    int          wt;
    int          errx;
    logic [31:0] r0, r1, r2;
    int          gi;
    int          gexp;
    int          nx;
    bit          d;
    bit          e;
    int          ei;
  } vec_t;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       start_i = 1'b0;
  tbl_t       table_i;
  logic       busy_o, done_o, error_o;
  logic [2:0] err_idx_o;

  rpc_reg_init_seq_if bus ();

  rpc_reg_init_seq #(
    .NumEntries (NE),
    .PollGap    (PG),
    .PollTimeout(PT)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .table_i  (table_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .error_o  (error_o),
    .err_idx_o(err_idx_o),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Responder state shared with the run task.
  int          resp_wait = 0;
  int          err_xfer  = -1;
  int          xfer_n    = 0;
  int          rd_n      = 0;
  int          wait_left = 0;
  int          first_valid_cyc = -1;
  bit          in_xfer   = 1'b0;
  logic [31:0] rd_arr [256];
  logic [84:0] snap;
  xfer_t       log_q[$];
  xfer_t       exp_q[$];

  initial begin
    bus.reg_ready_i = 1'b0;
    bus.reg_error_i = 1'b0;
    bus.reg_rdata_i = '0;
  end

  // Responder: decides ready/error/rdata at the falling edge, logs handshakes.
  always @(negedge clk_i) begin
    if (rst_ni && bus.reg_valid_o) begin
      if (!in_xfer) begin
        in_xfer   = 1'b1;
        wait_left = resp_wait;
        snap      = {bus.reg_addr_o, bus.reg_write_o, bus.reg_wdata_o, bus.reg_wstrb_o};
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end else begin
        chk("req_stable", {bus.reg_addr_o, bus.reg_write_o, bus.reg_wdata_o, bus.reg_wstrb_o}, snap);
      end
      if (wait_left > 0) begin
        wait_left--;
        bus.reg_ready_i = 1'b0;
        bus.reg_error_i = 1'b0;
        bus.reg_rdata_i = $urandom;
      end else begin
        bus.reg_ready_i = 1'b1;
        bus.reg_error_i = (xfer_n == err_xfer);
        if (!bus.reg_write_o) begin
          bus.reg_rdata_i = rd_arr[rd_n % 256];
          rd_n++;
        end else begin
          bus.reg_rdata_i = $urandom;
        end
        log_q.push_back('{cyc, bus.reg_write_o, bus.reg_addr_o, bus.reg_wdata_o, bus.reg_wstrb_o});
        xfer_n++;
        in_xfer = 1'b0;
      end
    end else begin
      in_xfer = 1'b0;
      // Ready/error noise while no request is pending must be ignored.
      bus.reg_ready_i = 1'($urandom_range(0, 1));
      bus.reg_error_i = 1'($urandom_range(0, 1));
      bus.reg_rdata_i = $urandom;
    end
  end

  function automatic entry_t mk(input op_e op, input logic [47:0] a,
                                input logic [31:0] d, input logic [31:0] m);
    entry_t e;
    e.op   = op;
    e.addr = a;
    e.data = d;
    e.mask = m;
    return e;
  endfunction

  function automatic tbl_t all_end();
    tbl_t t;
    for (int i = 0; i < NE; i++) t[i] = mk(OP_END, '0, '0, '0);
    return t;
  endfunction

  // Transaction-level model: walks the table, consumes reads from rd_arr.
  task automatic model(input tbl_t t, output bit d, output bit e, output int ei);
    int          idx;
    int          xn;
    int          rn;
    bit          fin;
    bit          matched;
    entry_t      en;
    logic [31:0] rd;
    idx = 0; xn = 0; rn = 0; fin = 0;
    d = 0; e = 0; ei = 0;
    exp_q.delete();
    while (!fin) begin
      if (idx >= NE) begin
        d = 1; fin = 1;
      end else begin
        en = t[idx];
        case (en.op)
          OP_WRITE: begin
            exp_q.push_back('{0, 1'b1, en.addr, en.data, 4'hF});
            if (xn == err_xfer) begin e = 1; ei = idx; fin = 1; end
            xn++;
            idx++;
          end
          OP_POLL: begin
            matched = 0;
            for (int k = 0; k < PT && !matched && !fin; k++) begin
              exp_q.push_back('{0, 1'b0, en.addr, 32'h0, 4'h0});
              rd = rd_arr[rn % 256];
              rn++;
              if (xn == err_xfer) begin e = 1; ei = idx; fin = 1; end
              else if ((rd & en.mask) == (en.data & en.mask)) matched = 1;
              xn++;
            end
            if (!fin) begin
              if (matched) idx++;
              else begin e = 1; ei = idx; fin = 1; end
            end
          end
          OP_WAIT: idx++;
          default: begin d = 1; fin = 1; end
        endcase
      end
    end
  endtask

  task automatic compare_run(input string tag);
    bit d, e;
    int ei;
    int n;
    model(table_i, d, e, ei);
    chk({tag, "_nxfer"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wr"},    log_q[i].wr,    exp_q[i].wr);
      chk({tag, "_addr"},  log_q[i].addr,  exp_q[i].addr);
      chk({tag, "_wstrb"}, log_q[i].wstrb, exp_q[i].wstrb);
      if (exp_q[i].wr) chk({tag, "_wdata"}, log_q[i].wdata, exp_q[i].wdata);
    end
    chk({tag, "_done"},    done_o,    d);
    chk({tag, "_error"},   error_o,   e);
    chk({tag, "_err_idx"}, err_idx_o, ei[2:0]);
    chk({tag, "_valid_idle"}, bus.reg_valid_o, 1'b0);
  endtask

  task automatic run(input tbl_t t, input int wt, input int errx, input bit poke, output int sc);
    int n;
    table_i         = t;
    resp_wait       = wt;
    err_xfer        = errx;
    xfer_n          = 0;
    rd_n            = 0;
    first_valid_cyc = -1;
    log_q.delete();
    @(negedge clk_i);
    start_i = 1'b1;
    sc      = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    chk("done_cleared",     done_o, 1'b0);
    chk("error_cleared",    error_o, 1'b0);
    if (poke) begin
      @(negedge clk_i);
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
    end
    n = 0;
    while (busy_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("run_finished", busy_o, 1'b0);
  endtask

  vec_t        vecs[8];
  tbl_t        t;
  int          sc;
  logic [63:0] r64;
  int          r;

  initial begin
    // Directed vector table.
    t = all_end();
    t[0] = mk(OP_WRITE, 48'h10, 32'hA5, '0);
    t[1] = mk(OP_WRITE, 48'h14, 32'h3, '0);
    vecs[0] = '{"two_wr_0ws", t, 0, -1, 0, 0, 0, 0, 2, 2, 1, 0, 0};
    vecs[1] = '{"two_wr_3ws", t, 3, -1, 0, 0, 0, 0, 5, 2, 1, 0, 0};

    t = all_end();
    t[0] = mk(OP_POLL,  48'h20, 32'h1, 32'h1);
    t[1] = mk(OP_WRITE, 48'h30, 32'h7, '0);
    vecs[2] = '{"poll_match3", t, 0, -1, 32'h0, 32'h0, 32'h3, 0, PG + 1, 4, 1, 0, 0};

    t = all_end();
    t[0] = mk(OP_WRITE, 48'h18, 32'h55, '0);
    t[1] = mk(OP_POLL,  48'h20, 32'h1, 32'h1);
    vecs[3] = '{"poll_timeout", t, 0, -1, 0, 0, 0, 1, PG + 1, 5, 0, 1, 1};

    t = all_end();
    for (int i = 0; i < 4; i++) t[i] = mk(OP_WRITE, 48'h100 + 48'(4 * i), 32'(i + 1), '0);
    vecs[4] = '{"bus_err_e2", t, 0, 2, 0, 0, 0, 0, 2, 3, 0, 1, 2};

    t = all_end();
    t[0] = mk(OP_WRITE, 48'h10, 32'hA5, '0);
    t[1] = mk(OP_WAIT,  48'h0,  32'd5,  '0);
    t[2] = mk(OP_WRITE, 48'h14, 32'h3,  '0);
    vecs[5] = '{"wait5", t, 0, -1, 0, 0, 0, 0, 8, 2, 1, 0, 0};
    t[1] = mk(OP_WAIT,  48'h0,  32'd0,  '0);
    vecs[6] = '{"wait0", t, 0, -1, 0, 0, 0, 0, 4, 2, 1, 0, 0};

    for (int i = 0; i < NE; i++) t[i] = mk(OP_WRITE, 48'h200 + 48'(4 * i), 32'(i), '0);
    vecs[7] = '{"wrap_no_end", t, 0, -1, 0, 0, 0, 0, 2, NE, 1, 0, 0};

    table_i = all_end();
    for (int i = 0; i < 256; i++) rd_arr[i] = '0;

    // Reset state.
    #1;
    chk("rst_busy",    busy_o, 1'b0);
    chk("rst_done",    done_o, 1'b0);
    chk("rst_error",   error_o, 1'b0);
    chk("rst_err_idx", err_idx_o, 3'd0);
    chk("rst_valid",   bus.reg_valid_o, 1'b0);
    chk("rst_wstrb",   bus.reg_wstrb_o, 4'h0);
    #21 rst_ni = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 256; i++) rd_arr[i] = '0;
      rd_arr[0] = vecs[v].r0;
      rd_arr[1] = vecs[v].r1;
      rd_arr[2] = vecs[v].r2;
      run(vecs[v].t, vecs[v].wt, vecs[v].errx, 1'b1, sc);
      chk({vecs[v].nm, "_first_req_lat"}, first_valid_cyc - sc, 2);
      chk({vecs[v].nm, "_nx"}, log_q.size(), vecs[v].nx);
      if (log_q.size() > vecs[v].gi + 1)
        chk({vecs[v].nm, "_gap"}, log_q[vecs[v].gi + 1].cyc - log_q[vecs[v].gi].cyc, vecs[v].gexp);
      else
        chk({vecs[v].nm, "_gap_xfers"}, log_q.size(), vecs[v].gi + 2);
      chk({vecs[v].nm, "_done"},    done_o,    vecs[v].d);
      chk({vecs[v].nm, "_error"},   error_o,   vecs[v].e);
      chk({vecs[v].nm, "_err_idx"}, err_idx_o, vecs[v].ei[2:0]);
      compare_run(vecs[v].nm);
    end

    // Reset asserted while a request is waiting for ready.
    t = all_end();
    t[0] = mk(OP_WRITE, 48'h40, 32'h1234, '0);
    table_i   = t;
    resp_wait = 50;
    err_xfer  = -1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 10 && !bus.reg_valid_o; i++) @(negedge clk_i);
    chk("midrst_valid_before", bus.reg_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_valid", bus.reg_valid_o, 1'b0);
    chk("midrst_busy",  busy_o, 1'b0);
    chk("midrst_done",  done_o, 1'b0);
    chk("midrst_error", error_o, 1'b0);
    chk("midrst_eidx",  err_idx_o, 3'd0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("post_rst_idle_busy",  busy_o, 1'b0);
      chk("post_rst_idle_valid", bus.reg_valid_o, 1'b0);
    end

    // Random tables against the model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NE; i++) begin
        r   = $urandom_range(0, 99);
        r64 = {$urandom, $urandom};
        if (r < 40)      t[i] = mk(OP_WRITE, r64[47:0], $urandom, '0);
        else if (r < 65) t[i] = mk(OP_POLL, r64[47:0], $urandom, 32'(1) << $urandom_range(0, 3));
        else if (r < 85) t[i] = mk(OP_WAIT, r64[47:0], 32'($urandom_range(0, 6)), '0);
        else             t[i] = mk(OP_END, r64[47:0], '0, '0);
      end
      for (int i = 0; i < 256; i++) rd_arr[i] = $urandom;
      r = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
      run(t, $urandom_range(0, 2), r, 1'b0, sc);
      compare_run("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
